// File: rtl/sblk_pkg.sv
// sblk_pkg -- definitions shared by the SuperBlock write-side blocks.
//
// Contents:
//   SBLK_NTILE    number of SuperTiles fed (must match the SuperBlock).
//   SBLK_W_BIT    weight word width; also the stream width.
//   SBLK_ACT_BIT  activation word width (<= SBLK_W_BIT).
//   SBLK_LEN_BIT  width of the per-tile word count field.
//   sblk_loader_state_t  loader FSM states.
package sblk_pkg;

  localparam int SBLK_NTILE   = 4;
  localparam int SBLK_W_BIT   = 16;
  localparam int SBLK_ACT_BIT = 16;
  localparam int SBLK_LEN_BIT = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEQ   = 2'd1,
    BCAST = 2'd2,
    FIN   = 2'd3
  } sblk_loader_state_t;

endpackage

// File: rtl/sblk_loader_if.sv
// sblk_loader_if -- command channel plus input word stream of sblk_loader.
//
// Signals:
//   cmd_valid/cmd_ready  command handshake (accept on valid && ready)
//   cmd_act              0 = weight ports, 1 = activation ports
//   cmd_bcast            0 = sequential, 1 = broadcast
//   cmd_mask [NTILE]     tiles to load
//   cmd_len  [LEN_BIT]   words per tile, minus 1
//   in_data  [W_BIT]     stream data
//   in_valid/in_ready    stream handshake (beat on valid && ready)
// Modports:
//   master  the DMA/host side that issues commands and data
//   slave   the loader
interface sblk_loader_if
  import sblk_pkg::*;
#(
  parameter int NTILE   = SBLK_NTILE,
  parameter int W_BIT   = SBLK_W_BIT,
  parameter int LEN_BIT = SBLK_LEN_BIT
);

  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_act;
  logic               cmd_bcast;
  logic [NTILE-1:0]   cmd_mask;
  logic [LEN_BIT-1:0] cmd_len;
  logic [W_BIT-1:0]   in_data;
  logic               in_valid;
  logic               in_ready;

  modport master (
    output cmd_valid, cmd_act, cmd_bcast, cmd_mask, cmd_len, in_data, in_valid,
    input  cmd_ready, in_ready
  );

  modport slave (
    input  cmd_valid, cmd_act, cmd_bcast, cmd_mask, cmd_len, in_data, in_valid,
    output cmd_ready, in_ready
  );

endinterface

// File: rtl/sblk_next_tile.sv
// sblk_next_tile -- lowest set mask bit strictly above a given index.
//
// Ports:
//   mask_i  [NTILE]    candidate tiles
//   idx_i   [IDX_W+1]  signed start index; -1 searches from tile 0
//   idx_o   [IDX_W]    index of the lowest set bit above idx_i (0 if none)
//   none_o             no set bit above idx_i
// Purely combinational.
module sblk_next_tile #(
  parameter int NTILE = 4,
  parameter int IDX_W = 2
) (
  input  logic [NTILE-1:0]  mask_i,
  input  logic signed [IDX_W:0] idx_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              none_o
);

  logic [NTILE-1:0] above;

  for (genvar gi = 0; gi < NTILE; gi++) begin : g_above
    assign above[gi] = mask_i[gi] && (gi > int'(idx_i));
  end

  // Scan downwards so the lowest qualifying bit is the last one written.
  always_comb begin
    idx_o  = '0;
    none_o = 1'b1;
    for (int i = NTILE - 1; i >= 0; i--) begin
      if (above[i]) begin
        idx_o  = IDX_W'(i);
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sblk_loader.sv
// sblk_loader -- write-side feeder for one SuperBlock (clk_l domain only).
//
// Takes load commands and one word stream, and drives the per-SuperTile
// weight or activation write ports. Sequential commands give each masked
// tile its own block of cmd_len+1 words in ascending tile order; broadcast
// commands write each word to all masked tiles at once.
//
// Ports:
//   clk_l, rst      clock, synchronous active-high reset
//   bus (slave)     command channel and input stream
//   w_wr_data/en    weight write ports, NTILE x W_BIT
//   act_wr_data/en  activation write ports, NTILE x ACT_BIT (low bits of in_data)
//   done            one-cycle pulse when a command completes
//   err             one-cycle pulse with done when the command had an empty mask
//   wr_count        (only with SBLK_LOADER_CNT_EN) total beats accepted since reset
//
// Write ports are registered: a beat accepted in cycle M writes in M+1.
module sblk_loader
  import sblk_pkg::*;
#(
  parameter int NTILE   = SBLK_NTILE,
  parameter int W_BIT   = SBLK_W_BIT,
  parameter int ACT_BIT = SBLK_ACT_BIT,
  parameter int LEN_BIT = SBLK_LEN_BIT
) (
  input  logic                     clk_l,
  input  logic                     rst,
  sblk_loader_if.slave             bus,
  output logic [NTILE*W_BIT-1:0]   w_wr_data,
  output logic [NTILE-1:0]         w_wr_en,
  output logic [NTILE*ACT_BIT-1:0] act_wr_data,
  output logic [NTILE-1:0]         act_wr_en,
  output logic                     done,
  output logic                     err
`ifdef SBLK_LOADER_CNT_EN
  ,
  output logic [31:0]              wr_count
`endif
);

  localparam int IDX_W = (NTILE > 1) ? $clog2(NTILE) : 1;

  sblk_loader_state_t state_q, state_d;
  logic               act_q, act_d;
  logic               bcast_q, bcast_d;
  logic [NTILE-1:0]   mask_q, mask_d;
  logic [LEN_BIT-1:0] len_q, len_d;
  logic [LEN_BIT-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               err_q, err_d;

  logic cmd_ready_c, in_ready_c;
  logic in_ready_o;
  logic beat;
  logic [NTILE-1:0] sel;

  logic [NTILE-1:0]      nt_mask;
  logic signed [IDX_W:0] nt_from;
  logic [IDX_W-1:0]      nt_idx;
  logic                  nt_none;

  logic [NTILE-1:0]         w_en_q, act_en_q;
  logic [NTILE*W_BIT-1:0]   w_data_q;
  logic [NTILE*ACT_BIT-1:0] act_data_q;

  // In IDLE the search runs over the incoming mask from index -1 to find the
  // first tile; in SEQ it advances from the current tile over the latched mask.
  assign nt_mask = (state_q == IDLE) ? bus.cmd_mask : mask_q;
  assign nt_from = (state_q == IDLE) ? '1 : $signed({1'b0, idx_q});

  sblk_next_tile #(
    .NTILE (NTILE),
    .IDX_W (IDX_W)
  ) u_next_tile (
    .mask_i (nt_mask),
    .idx_i  (nt_from),
    .idx_o  (nt_idx),
    .none_o (nt_none)
  );

  // Handshakes are held low while reset is asserted so nothing is taken
  // during reset, whatever state the FSM was in.
  assign bus.cmd_ready = cmd_ready_c & ~rst;
  assign in_ready_o    = in_ready_c & ~rst;
  assign bus.in_ready  = in_ready_o;
  assign beat          = in_ready_o & bus.in_valid;

  // Tiles written by the current beat.
  for (genvar gi = 0; gi < NTILE; gi++) begin : g_sel
    assign sel[gi] = bcast_q ? mask_q[gi] : (idx_q == IDX_W'(gi));
  end

  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    bcast_d     = bcast_q;
    mask_d      = mask_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    err_d       = err_q;
    cmd_ready_c = 1'b0;
    in_ready_c  = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) begin
          act_d   = bus.cmd_act;
          bcast_d = bus.cmd_bcast;
          mask_d  = bus.cmd_mask;
          len_d   = bus.cmd_len;
          cnt_d   = '0;
          err_d   = (bus.cmd_mask == '0);
          if (bus.cmd_mask == '0) begin
            state_d = FIN;
          end else if (bus.cmd_bcast) begin
            state_d = BCAST;
          end else begin
            idx_d   = nt_idx;
            state_d = SEQ;
          end
        end
      end

      SEQ: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          if (cnt_q == len_q) begin
            cnt_d = '0;
            if (nt_none) begin
              state_d = FIN;
            end else begin
              idx_d = nt_idx;
            end
          end else begin
            cnt_d = cnt_q + LEN_BIT'(1);
          end
        end
      end

      BCAST: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          if (cnt_q == len_q) begin
            cnt_d   = '0;
            state_d = FIN;
          end else begin
            cnt_d = cnt_q + LEN_BIT'(1);
          end
        end
      end

      FIN: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_l) begin
    if (rst) begin
      state_q    <= IDLE;
      act_q      <= 1'b0;
      bcast_q    <= 1'b0;
      mask_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      w_en_q     <= '0;
      act_en_q   <= '0;
      w_data_q   <= '0;
      act_data_q <= '0;
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      bcast_q  <= bcast_d;
      mask_q   <= mask_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      w_en_q   <= (beat && !act_q) ? sel : '0;
      act_en_q <= (beat &&  act_q) ? sel : '0;
      // Only the slices actually written change; all others hold.
      for (int t = 0; t < NTILE; t++) begin
        if (beat && !act_q && sel[t]) begin
          w_data_q[t*W_BIT +: W_BIT] <= bus.in_data;
        end
        if (beat && act_q && sel[t]) begin
          act_data_q[t*ACT_BIT +: ACT_BIT] <= bus.in_data[ACT_BIT-1:0];
        end
      end
    end
  end

  assign w_wr_en     = w_en_q;
  assign act_wr_en   = act_en_q;
  assign w_wr_data   = w_data_q;
  assign act_wr_data = act_data_q;
  assign done        = (state_q == FIN);
  assign err         = (state_q == FIN) && err_q;

`ifdef SBLK_LOADER_CNT_EN
  logic [31:0] wr_count_q;

  always_ff @(posedge clk_l) begin
    if (rst) begin
      wr_count_q <= '0;
    end else if (beat) begin
      wr_count_q <= wr_count_q + 32'd1;
    end
  end

  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_sblk_loader.sv
// tb_sblk_loader -- directed self-checking bench for sblk_loader.
// Inputs are driven and outputs sampled on the falling edge of clk_l.
module tb_sblk_loader;

  localparam int NT = 4;
  localparam int WB = 16;
  localparam int AB = 16;
  localparam int LB = 10;

  logic clk_l = 1'b0;
  logic rst;
  logic [NT*WB-1:0] w_wr_data;
  logic [NT-1:0]    w_wr_en;
  logic [NT*AB-1:0] act_wr_data;
  logic [NT-1:0]    act_wr_en;
  logic             done;
  logic             err;
`ifdef SBLK_LOADER_CNT_EN
  logic [31:0]      wr_count;
`endif

  int checks = 0;
  int errors = 0;

  sblk_loader_if #(.NTILE(NT), .W_BIT(WB), .LEN_BIT(LB)) bus ();

  sblk_loader #(
    .NTILE   (NT),
    .W_BIT   (WB),
    .ACT_BIT (AB),
    .LEN_BIT (LB)
  ) dut (
    .clk_l       (clk_l),
    .rst         (rst),
    .bus         (bus),
    .w_wr_data   (w_wr_data),
    .w_wr_en     (w_wr_en),
    .act_wr_data (act_wr_data),
    .act_wr_en   (act_wr_en),
    .done        (done),
    .err         (err)
`ifdef SBLK_LOADER_CNT_EN
    ,
    .wr_count    (wr_count)
`endif
  );

  always #5 clk_l = ~clk_l;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish before 400000");
    $fatal(1, "watchdog");
  end

  // Presents a command (called on a falling edge) and returns on the falling
  // edge of the cycle after acceptance.
  task automatic send_cmd(input logic act, input logic bcast,
                          input logic [NT-1:0] mask, input logic [LB-1:0] len);
    int w = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_act   = act;
    bus.cmd_bcast = bcast;
    bus.cmd_mask  = mask;
    bus.cmd_len   = len;
    while (bus.cmd_ready !== 1'b1 && w < 20) begin
      @(negedge clk_l);
      w++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept: cmd_ready=%b required 1", bus.cmd_ready);
    end
    @(negedge clk_l);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_act   = 1'b0;
    bus.cmd_bcast = 1'b0;
    bus.cmd_mask  = '0;
    bus.cmd_len   = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    repeat (3) @(negedge clk_l);
    checks++;
    if (bus.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_cmd_ready: got %b required 0", bus.cmd_ready);
    end
    checks++;
    if ({bus.in_ready, w_wr_en, act_wr_en, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready/w_en/act_en/done/err=%b required 0",
               {bus.in_ready, w_wr_en, act_wr_en, done, err});
    end
    checks++;
    if ({w_wr_data, act_wr_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: w=%h act=%h required 0", w_wr_data, act_wr_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 1", bus.cmd_ready);
    end
    $display("tx reset: released");
  endtask

  // mask 1011, len 2, data 1..9 -> tiles 0,0,0,1,1,1,3,3,3
  task automatic test_seq_weights();
    int tl[3] = '{0, 1, 3};
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic prev_beat = 1'b0;
    logic [NT-1:0] exp_en;
    send_cmd(1'b0, 1'b0, 4'b1011, 10'd2);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL seq_first_in_ready: got %b required 1", bus.in_ready);
    end
    while (got < 9 && cyc < 100) begin
      if (prev_beat) begin
        exp_en = 4'b0001 << tl[got/3];
        checks++;
        if (w_wr_en !== exp_en) begin
          errors++;
          $display("FAIL seq_w_en word %0d: got %b required %b", got + 1, w_wr_en, exp_en);
        end
        checks++;
        if (w_wr_data[tl[got/3]*WB +: WB] !== WB'(got + 1)) begin
          errors++;
          $display("FAIL seq_w_data word %0d: got %h required %h", got + 1,
                   w_wr_data[tl[got/3]*WB +: WB], WB'(got + 1));
        end
        checks++;
        if (done !== (got == 8)) begin
          errors++;
          $display("FAIL seq_done word %0d: got %b required %b", got + 1, done, (got == 8));
        end
        got++;
      end else begin
        checks++;
        if (w_wr_en !== '0) begin
          errors++;
          $display("FAIL seq_idle_en: got %b required 0", w_wr_en);
        end
      end
      checks++;
      if (act_wr_en !== '0) begin
        errors++;
        $display("FAIL seq_act_en: got %b required 0", act_wr_en);
      end
      if (sent < 9) begin
        bus.in_valid = 1'b1;
        bus.in_data  = WB'(sent + 1);
      end else begin
        bus.in_valid = 1'b0;
      end
      prev_beat = bus.in_valid && bus.in_ready;
      if (prev_beat) sent++;
      @(negedge clk_l);
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (got != 9) begin
      errors++;
      $display("FAIL seq_timeout: writes %0d required 9", got);
    end
    checks++;
    if ({bus.cmd_ready, done, w_wr_en} !== {1'b1, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL seq_after_done: ready/done/en=%b required 1_0_0000",
               {bus.cmd_ready, done, w_wr_en});
    end
    $display("tx seq weights mask=1011 len=2: %0d writes", got);
  endtask

  task automatic test_bcast_act();
    send_cmd(1'b1, 1'b1, 4'b0110, 10'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hABCD;
    @(negedge clk_l);
    bus.in_valid = 1'b0;
    checks++;
    if (act_wr_en !== 4'b0110) begin
      errors++;
      $display("FAIL bcast_act_en: got %b required 0110", act_wr_en);
    end
    checks++;
    if (act_wr_data[1*AB +: AB] !== 16'hABCD || act_wr_data[2*AB +: AB] !== 16'hABCD) begin
      errors++;
      $display("FAIL bcast_act_data: slice1=%h slice2=%h required abcd", act_wr_data[1*AB +: AB],
               act_wr_data[2*AB +: AB]);
    end
    checks++;
    if (act_wr_data[0 +: AB] !== 16'h0000 || act_wr_data[3*AB +: AB] !== 16'h0000) begin
      errors++;
      $display("FAIL bcast_unmasked_data: slice0=%h slice3=%h required 0000", act_wr_data[0 +: AB],
               act_wr_data[3*AB +: AB]);
    end
    checks++;
    if ({w_wr_en, done, err} !== {4'b0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL bcast_w_en_done: w_en/done/err=%b required 0000_1_0", {w_wr_en, done, err});
    end
    checks++;
    if (w_wr_data[3*WB +: WB] !== 16'h0009) begin
      errors++;
      $display("FAIL bcast_w_hold: tile3 weight=%h required 0009", w_wr_data[3*WB +: WB]);
    end
    @(negedge clk_l);
    checks++;
    if ({bus.cmd_ready, done, act_wr_en} !== {1'b1, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL bcast_after: ready/done/act_en=%b required 1_0_0000",
               {bus.cmd_ready, done, act_wr_en});
    end
    $display("tx bcast act mask=0110 len=0 data=abcd");
  endtask

  task automatic test_empty_mask();
    send_cmd(1'b0, 1'b0, 4'b0000, 10'd5);
    checks++;
    if ({done, err, bus.in_ready, bus.cmd_ready} !== 4'b1100) begin
      errors++;
      $display("FAIL empty_fin: done/err/in_ready/cmd_ready=%b required 1100",
               {done, err, bus.in_ready, bus.cmd_ready});
    end
    @(negedge clk_l);
    checks++;
    if ({done, err, bus.in_ready, bus.cmd_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL empty_after: done/err/in_ready/cmd_ready=%b required 0001",
               {done, err, bus.in_ready, bus.cmd_ready});
    end
    $display("tx empty mask len=5: err");
  endtask

  // mask 1111, len 3, data 0x100..0x10f with random stream gaps.
  task automatic test_gaps();
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int gaps = 0;
    logic prev_beat = 1'b0;
    logic [NT-1:0] exp_en;
    send_cmd(1'b0, 1'b0, 4'b1111, 10'd3);
    while (got < 16 && cyc < 400) begin
      if (prev_beat) begin
        exp_en = 4'b0001 << (got / 4);
        checks++;
        if (w_wr_en !== exp_en) begin
          errors++;
          $display("FAIL gap_w_en word %0d: got %b required %b", got, w_wr_en, exp_en);
        end
        checks++;
        if (w_wr_data[(got/4)*WB +: WB] !== WB'(32'h100 + got)) begin
          errors++;
          $display("FAIL gap_w_data word %0d: got %h required %h", got,
                   w_wr_data[(got/4)*WB +: WB], WB'(32'h100 + got));
        end
        checks++;
        if (done !== (got == 15)) begin
          errors++;
          $display("FAIL gap_done word %0d: got %b required %b", got, done, (got == 15));
        end
        got++;
      end else begin
        checks++;
        if (w_wr_en !== '0) begin
          errors++;
          $display("FAIL gap_idle_en cycle %0d: got %b required 0000", cyc, w_wr_en);
        end
      end
      if (sent < 16 && $urandom_range(0, 2) != 0) begin
        bus.in_valid = 1'b1;
        bus.in_data  = WB'(32'h100 + sent);
      end else begin
        bus.in_valid = 1'b0;
        gaps++;
      end
      prev_beat = bus.in_valid && bus.in_ready;
      if (prev_beat) sent++;
      @(negedge clk_l);
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (got != 16) begin
      errors++;
      $display("FAIL gap_timeout: writes %0d required 16", got);
    end
    @(negedge clk_l);
    $display("tx seq gaps mask=1111 len=3: %0d writes, %0d idle cycles", got, gaps);
  endtask

  // Activation load of 12 beats, aborted by reset after 5 beats.
  task automatic test_reset_mid();
    send_cmd(1'b1, 1'b0, 4'b0111, 10'd3);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = WB'(32'h200 + k);
      @(negedge clk_l);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (act_wr_en !== 4'b0010 || act_wr_data[1*AB +: AB] !== 16'h0204) begin
      errors++;
      $display("FAIL rmid_fifth: act_en=%b data=%h required 0010 0204", act_wr_en,
               act_wr_data[1*AB +: AB]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.cmd_ready, bus.in_ready} !== 2'b00) begin
      errors++;
      $display("FAIL rmid_ready_in_reset: cmd_ready/in_ready=%b required 00",
               {bus.cmd_ready, bus.in_ready});
    end
    @(negedge clk_l);
    checks++;
    if ({w_wr_en, act_wr_en, done, err} !== '0) begin
      errors++;
      $display("FAIL rmid_en: w_en/act_en/done/err=%b required 0",
               {w_wr_en, act_wr_en, done, err});
    end
    @(negedge clk_l);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL rmid_done: got %b required 0", done);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_release_ready: got %b required 1", bus.cmd_ready);
    end
    $display("tx seq act mask=0111 len=3: aborted after 5 beats");
    send_cmd(1'b0, 1'b0, 4'b0001, 10'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h5A5A;
    @(negedge clk_l);
    bus.in_valid = 1'b0;
    checks++;
    if ({w_wr_en, act_wr_en, done} !== {4'b0001, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL rmid_new_cmd: w_en/act_en/done=%b required 0001_0000_1",
               {w_wr_en, act_wr_en, done});
    end
    checks++;
    if (w_wr_data[0 +: WB] !== 16'h5A5A) begin
      errors++;
      $display("FAIL rmid_new_data: got %h required 5a5a", w_wr_data[0 +: WB]);
    end
    @(negedge clk_l);
    checks++;
    if ({bus.cmd_ready, done} !== 2'b10) begin
      errors++;
      $display("FAIL rmid_new_after: cmd_ready/done=%b required 10", {bus.cmd_ready, done});
    end
    $display("tx seq weights mask=0001 len=0 data=5a5a");
  endtask

`ifdef SBLK_LOADER_CNT_EN
  task automatic test_count();
    rst = 1'b1;
    repeat (2) @(negedge clk_l);
    checks++;
    if (wr_count !== 32'd0) begin
      errors++;
      $display("FAIL count_reset: got %0d required 0", wr_count);
    end
    rst = 1'b0;
    send_cmd(1'b0, 1'b0, 4'b1011, 10'd2);
    for (int k = 0; k < 9; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = WB'(k);
      @(negedge clk_l);
    end
    bus.in_valid = 1'b0;
    @(negedge clk_l);
    send_cmd(1'b1, 1'b1, 4'b1000, 10'd0);
    bus.in_valid = 1'b1;
    @(negedge clk_l);
    bus.in_valid = 1'b0;
    @(negedge clk_l);
    checks++;
    if (wr_count !== 32'd10) begin
      errors++;
      $display("FAIL count_total: got %0d required 10", wr_count);
    end
    $display("tx count: wr_count=%0d", wr_count);
  endtask
`endif

  initial begin
    test_reset();
    test_seq_weights();
    test_bcast_act();
    test_empty_mask();
    test_gaps();
    test_reset_mid();
`ifdef SBLK_LOADER_CNT_EN
    test_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
